// File: rtl/aes_comm_pkg.sv
// rtl/aes_comm_pkg.sv - shared constants and helpers for the AES communication path
package aes_comm_pkg;

  localparam int AES_BLOCK_W     = 128;
  localparam int COMM_FIFO_DEPTH = 8;

  // Ceiling log2 usable in parameter expressions; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_fifo_mem.sv
// rtl/aes_fifo_mem.sv - block storage with synchronous write and asynchronous read
module aes_fifo_mem
  import aes_comm_pkg::*;
#(
  parameter int DATA_W = AES_BLOCK_W,
  parameter int DEPTH  = COMM_FIFO_DEPTH,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/aes_block_fifo.sv
// rtl/aes_block_fifo.sv - first-word-fall-through block FIFO feeding the AES core
module aes_block_fifo
  import aes_comm_pkg::*;
#(
  parameter int DATA_W       = AES_BLOCK_W,
  parameter int DEPTH        = COMM_FIFO_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     flush,
  input  logic                     clear_err
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] AFULL_LVL = AFULL_THRESH[AW:0];

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       occ;
  logic [DATA_W-1:0] head;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  // Wrap bit distinguishes full from empty when the low address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign wr_ready    = !full;
  assign rd_valid    = !empty;
  assign push        = wr_valid && wr_ready && !flush;
  assign pop         = rd_valid && rd_ready && !flush;
  assign count       = occ;
  assign almost_full = (occ >= AFULL_LVL);
  assign rd_data     = rd_valid ? head : '0;

  aes_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
    end
  end

  // Set beats clear when both happen in the same cycle; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (wr_valid && !wr_ready) begin
      overflow <= 1'b1;
    end else if (clear_err) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_block_fifo.sv
// tb/tb_aes_block_fifo.sv - directed self-checking bench for aes_block_fifo
module tb_aes_block_fifo;

  logic         clk;
  logic         reset;
  logic         wr_valid;
  logic         wr_ready;
  logic [127:0] wr_data;
  logic         rd_valid;
  logic         rd_ready;
  logic [127:0] rd_data;
  logic [3:0]   count;
  logic         almost_full;
  logic         overflow;
  logic         flush;
  logic         clear_err;

  int n_checks;
  int n_errors;
  logic [127:0] model_q [$];
  logic [127:0] exp_v;

  aes_block_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow),
    .flush       (flush),
    .clear_err   (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;
    flush     = 1'b0;
    clear_err = 1'b0;
    step();
    step();
    reset = 1'b1;

    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_count", count, 0);
    check("rst_afull", almost_full, 0);
    check("rst_overflow", overflow, 0);

    // single push then pop
    wr_valid = 1'b1;
    wr_data  = 128'h00112233445566778899AABBCCDDEEFF;
    step();
    wr_valid = 1'b0;
    check("single_rd_valid", rd_valid, 1);
    check("single_rd_data", rd_data, 128'h00112233445566778899AABBCCDDEEFF);
    check("single_count", count, 1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("single_pop_valid", rd_valid, 0);
    check("single_pop_data", rd_data, 0);
    check("single_pop_count", count, 0);

    // fill to DEPTH
    for (int i = 1; i <= 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = 128'(i);
      step();
      check($sformatf("fill_afull_%0d", i), almost_full, (i >= 6) ? 1 : 0);
    end
    wr_valid = 1'b0;
    check("full_wr_ready", wr_ready, 0);
    check("full_count", count, 8);
    check("full_no_ovf", overflow, 0);

    wr_valid = 1'b1;
    wr_data  = 128'h99;
    step();
    wr_valid = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 8);

    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_data_%0d", i), rd_data, 128'(i));
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
    check("drain_empty", rd_valid, 0);
    check("drain_count", count, 0);
    check("ovf_sticky", overflow, 1);

    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("ovf_cleared", overflow, 0);

    // steady-state push+pop at count=3
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      wr_data  = 128'(100 + k);
      model_q.push_back(wr_data);
      step();
    end
    wr_valid = 1'b0;
    check("stream_start_count", count, 3);
    for (int k = 0; k < 20; k++) begin
      exp_v = model_q.pop_front();
      check($sformatf("stream_data_%0d", k), rd_data, exp_v);
      wr_valid = 1'b1;
      rd_ready = 1'b1;
      wr_data  = 128'(103 + k);
      model_q.push_back(wr_data);
      step();
      check($sformatf("stream_count_%0d", k), count, 3);
    end
    wr_valid = 1'b0;
    while (model_q.size() > 0) begin
      exp_v = model_q.pop_front();
      check("stream_tail_data", rd_data, exp_v);
      step();
    end
    rd_ready = 1'b0;
    check("stream_empty", rd_valid, 0);
    check("stream_no_ovf", overflow, 0);

    // flush overrides push and pop
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1;
      wr_data  = 128'(200 + k);
      step();
    end
    check("preflush_count", count, 4);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 128'hDEAD;
    rd_ready = 1'b1;
    step();
    flush    = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    check("flush_count", count, 0);
    check("flush_rd_valid", rd_valid, 0);
    check("flush_no_ovf", overflow, 0);
    wr_valid = 1'b1;
    wr_data  = 128'h300;
    step();
    wr_valid = 1'b0;
    check("postflush_data", rd_data, 128'h300);
    check("postflush_count", count, 1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("postflush_empty", rd_valid, 0);

    // set-wins-over-clear
    for (int k = 0; k < 8; k++) begin
      wr_valid = 1'b1;
      wr_data  = 128'(400 + k);
      step();
    end
    step();
    check("refull_ovf", overflow, 1);
    clear_err = 1'b1;
    step();
    check("set_beats_clear", overflow, 1);
    wr_valid = 1'b0;
    step();
    clear_err = 1'b0;
    check("clear_after", overflow, 0);
    check("refull_head", rd_data, 128'd400);

    // reset mid-burst at count=5
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    rd_ready = 1'b0;
    check("prerst_count", count, 5);
    wr_valid = 1'b1;
    wr_data  = 128'h555;
    rd_ready = 1'b1;
    reset    = 1'b0;
    step();
    reset    = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    check("midrst_count", count, 0);
    check("midrst_rd_valid", rd_valid, 0);
    check("midrst_rd_data", rd_data, 0);
    check("midrst_wr_ready", wr_ready, 1);
    check("midrst_afull", almost_full, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_block_fifo.md
Name: aes_block_fifo

Overview:
- Parametrised block FIFO between the UART/communication front end and the AES core.
- Buffers DEPTH blocks of DATA_W bits with a valid/ready handshake on both sides.
- First-word-fall-through: head data is presented without a read request.
- Supports simultaneous push/pop, occupancy count, almost-full, synchronous flush and a sticky overflow error.

Parameters:
DATA_W, 128, width of one block (AES block size)
DEPTH, 8, number of entries; power of two, >= 2
AFULL_THRESH, DEPTH-2, almost_full asserted when count >= AFULL_THRESH; range 1..DEPTH

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low
wr_valid  in  1  producer offers wr_data
wr_ready  out  1  FIFO can accept; push = wr_valid & wr_ready
wr_data  in  DATA_W  block to push
rd_valid  out  1  head entry available
rd_ready  in  1  consumer takes head; pop = rd_valid & rd_ready
rd_data  out  DATA_W  head entry; 0 when rd_valid=0
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full  out  1  count >= AFULL_THRESH
overflow  out  1  sticky; wr_valid seen while wr_ready=0
flush  in  1  synchronous empty request
clear_err  in  1  clears overflow

Behaviour:
- Reset (reset=0 at a clock edge): rd/wr pointers=0, count=0, overflow=0. Outputs then read wr_ready=1, rd_valid=0, rd_data=0, almost_full=0 (AFULL_THRESH>=1). Storage array is not reset.
- Pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - Pointer increments wrap naturally mod 2*DEPTH.
- wr_ready = !full; rd_valid = !empty. Both are combinational from registered state only. Neither depends on wr_valid or rd_ready.
- Push: mem[wr_ptr] <= wr_data, and wr_ptr increments at the edge.
- Latency: an entry pushed into an empty FIFO gives rd_valid=1 and rd_data = that entry in the next cycle.
- Pop: rd_ptr increments at the edge. The next entry, or rd_data=0 if the FIFO is now empty, is visible in the next cycle.
- Simultaneous push and pop:
  - Both occur in the same cycle; count unchanged.
  - When full, no push occurs even if popping (wr_ready already 0), so no pass-through.
  - When empty, only the push occurs (rd_valid=0).
- count: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH or goes below 0.
- overflow: set when wr_valid=1 and wr_ready=0 at an edge. The data is dropped and the FIFO state is unchanged.
- clear_err=1 clears overflow. If a set condition occurs in the same cycle, set wins.
- flush=1: pointers and count go to 0 at the edge.
  - Overrides any push or pop in that cycle; the pushed data is lost and no error is raised.
  - overflow is not affected by flush.
- Priority: reset > flush > push/pop.
- Reset mid-stream discards all content. The next cycle is identical to post-reset.
- The wrong-direction handshake rule is a producer/consumer obligation: wr_valid/wr_data must be held until wr_ready. It is not checked by the FIFO beyond the overflow flag.

Decomposition:
- Shared package aes_comm_pkg:
  - constant AES_BLOCK_W=128 (DATA_W default)
  - constant COMM_FIFO_DEPTH=8
  - clog2 helper function
- One sub-module aes_fifo_mem: DEPTH x DATA_W storage with a synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr -> rdata).
- Pointers, count, flags and the rd_data zero-mask live in aes_block_fifo.

Test Plan:
- Reset then idle -> wr_ready=1, rd_valid=0, rd_data=0, count=0, almost_full=0, overflow=0.
- Push 128'h00112233445566778899AABBCCDDEEFF with rd_ready=0 -> next cycle rd_valid=1, rd_data=that value, count=1. Pop -> following cycle rd_valid=0, rd_data=0.
- Push blocks 1..8 (DEPTH=8) with no pops:
  - almost_full rises after the 6th push; wr_ready=0 after the 8th; count=8.
  - A 9th wr_valid sets overflow=1; content unchanged.
  - Popping 8 times returns 1..8 in order.
- Continuous push+pop for 20 cycles starting at count=3 (pointers wrap twice) -> count stays 3, output order matches input order, no overflow.
- At count=4, assert flush together with wr_valid and rd_ready -> next cycle count=0, rd_valid=0. A later single push/pop returns only the new block.
- Set overflow, then pulse clear_err -> overflow=0. Assert clear_err in the same cycle as a full-FIFO write -> overflow stays 1. Drop reset mid-burst at count=5 -> count=0 next cycle.
